count_sample_fifo: RTL and testbench
====================================

// Module: count_sample_fifo
// PURPOSE
//  Downstream consumer of the free-running counter output driven onto io_out/la_data_out.
//  Snapshots count_i on an external trigger edge or on a programmable period and queues
//  the samples in a DEPTH-entry FIFO. The management SoC drains the FIFO over the
//  Wishbone slave port. Sits beside the counter inside the user project wrapper and shares its clock.
// PARAMETERS
//  BITS       32            width of count_i and of each FIFO entry (<=32)
//  DEPTH      8             FIFO entries; power of two, 2..64
//  ADDR_BASE  32'h3000_0000 Wishbone base; block decodes wbs_adr_i[31:8]==ADDR_BASE[31:8]
// PORTS
//  clk        in   1     single clock, also the Wishbone clock
//  rst_n      in   1     reset, asynchronous assert, active-low
//  wbs_stb_i  in   1     WB strobe
//  wbs_cyc_i  in   1     WB cycle
//  wbs_we_i   in   1     WB write enable
//  wbs_sel_i  in   4     WB byte selects; a write updates only the selected bytes
//  wbs_dat_i  in   32    WB write data
//  wbs_adr_i  in   32    WB byte address
//  wbs_ack_o  out  1     WB acknowledge
//  wbs_dat_o  out  32    WB read data
//  count_i    in   BITS  counter value to sample
//  trig_i     in   1     sample trigger, synchronous to clk; rising edge samples
//  irq_o      out  1     level interrupt (only with COUNT_SAMPLE_IRQ_EN)
// BEHAVIOUR
//  Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, all registers 0, FIFO empty.
//  WB: request = cyc&stb&address hit. ack asserts the cycle after the request, for one cycle only.
//   No back-to-back ack: a request is not re-acked while ack is high. Misses never ack.
//   wbs_dat_o is valid with ack and is 0 otherwise.
//  Register map (offset from ADDR_BASE; undefined offsets read 0, writes ignored):
//   0x00 CTRL   [0] EN  [1] PERIODIC  [2] FLUSH (self-clearing, reads 0)
//   0x04 PERIOD [15:0]; periodic sampling is disabled when PERIOD is 0
//   0x08 STATUS [6:0] level, [8] empty, [9] full, [10] OVF (sticky; write 1 to clear)
//   0x0C DATA   read pops the head entry, zero-extended to 32 bits. Reading when empty returns 0, no pop.
//   0x10 THRESH [6:0] irq level (meaningful with COUNT_SAMPLE_IRQ_EN only)
//  Trigger source: edge = trig_i & ~trig_q. trig_q is the 1-cycle delayed trig_i.
//  Period timer (16-bit):
//   - Runs only while EN and PERIODIC are set and PERIOD is non-zero; otherwise held at 0.
//   - A period tick fires when the timer reaches PERIOD-1; the timer then wraps to 0.
//     The first tick follows PERIOD cycles after enabling.
//  Sample event = EN & (edge | tick). Coincident edge and tick produce one sample.
//  Push: on a sample event, count_i from that same cycle is written into the FIFO.
//   Net latency from the trigger edge to the entry being visible in STATUS is 2 cycles.
//  Full: a sample event while full is dropped, OVF is set, and FIFO contents are unchanged.
//  Simultaneous pop and push:
//   - When full, both occur; level stays DEPTH and OVF is not set.
//   - When empty, a DATA read returns 0 and the push still lands.
//  Pointers are log2(DEPTH)+1 bits and wrap naturally. Level = wr_ptr - rd_ptr.
//  FLUSH: pointers go to 0 on the cycle after the write. FLUSH beats a same-cycle push. OVF is unaffected.
//  Clearing EN stops new samples; queued entries remain readable.
//  Reset mid-transfer: ack drops immediately, FIFO is emptied, and the in-flight WB cycle is not acked.
// CONFIGURATION
//  COUNT_SAMPLE_IRQ_EN defined: irq_o is registered, =1 when level>=THRESH and THRESH!=0, or when OVF=1.
//   It clears on the cycle after the condition clears.
//  Undefined: irq_o is tied 0, the THRESH register is absent (reads 0), and no threshold compare logic exists.
// TESTING
//  1. Reset, write CTRL=1, pulse trig_i with count_i=0x1234 -> STATUS level=1; DATA read returns 0x1234; then empty=1.
//  2. CTRL=3, PERIOD=4, count ramps by 1/cycle -> successive samples differ by 4; first sample lands 4 cycles after enable.
//  3. Take 10 samples with DEPTH=8 and no reads -> full=1, OVF=1, reads give the first 8 samples in order.
//     Then write STATUS=0x400 -> OVF=0.
//  4. Full FIFO, DATA read in the same cycle as a trigger edge -> level stays 8, OVF=0, oldest entry returned.
//  5. FLUSH write coincident with a trigger -> level=0, empty=1. Read DATA -> 0. Access offset 0x20 -> ack, data 0.
//  6. (IRQ_EN) THRESH=3, take 3 samples -> irq_o=1; one DATA read -> irq_o=0 the next cycle.
//     Assert rst_n=0 mid-read -> ack=0, irq_o=0.

Source files
------------

// File: rtl/count_sample_fifo.sv
// count_sample_fifo
// Snapshots count_i on a trigger rising edge or on a programmable period tick and
// queues the samples in a DEPTH-entry FIFO that the management SoC drains over the
// Wishbone slave port. Shares clk with the counter it observes.
// Optional feature macro: COUNT_SAMPLE_IRQ_EN -- adds the THRESH register and a
// registered level/overflow interrupt on irq_o. Without it irq_o is tied low.
module count_sample_fifo #(
    parameter int          BITS      = 32,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    input  logic            trig_i,
    output logic            irq_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_PERIOD = 8'h04;
    localparam logic [7:0] OFS_STATUS = 8'h08;
    localparam logic [7:0] OFS_DATA   = 8'h0C;
`ifdef COUNT_SAMPLE_IRQ_EN
    localparam logic [7:0] OFS_THRESH = 8'h10;
`endif

    // bus decode
    logic        hit;
    logic        req;
    logic        acc;
    logic        wr_acc;
    logic        rd_acc;
    logic [7:0]  ofs;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rd_data;

    // configuration / status
    logic        en;
    logic        periodic;
    logic [15:0] period;
    logic [15:0] period_m1;
    logic        ovf;
    logic        flush_w;
    logic        ovf_clr;

    // sampling
    logic [15:0] timer;
    logic        running;
    logic        tick;
    logic        trig_q;
    logic        trig_edge;
    logic        sample_ev;
    logic        smp_vld_q;
    logic [BITS-1:0] smp_dat_q;

    // fifo
    logic [BITS-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level;
    logic [6:0]  level7;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        drop;

    logic        unused_bits;

    assign hit    = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign req    = wbs_cyc_i & wbs_stb_i & hit;
    // A request is only taken while ack is low, so a held strobe is never double-acked.
    assign acc    = req & ~ack_q;
    assign wr_acc = acc & wbs_we_i;
    assign rd_acc = acc & ~wbs_we_i;
    assign ofs    = wbs_adr_i[7:0];

    assign flush_w = wr_acc && (ofs == OFS_CTRL) && wbs_sel_i[0] && wbs_dat_i[2];
    assign ovf_clr = wr_acc && (ofs == OFS_STATUS) && wbs_sel_i[1] && wbs_dat_i[10];

    assign level  = wr_ptr - rd_ptr;
    assign level7 = 7'(level);
    assign empty  = (level == '0);
    assign full   = (level == DEPTH_P);

    assign pop       = rd_acc && (ofs == OFS_DATA) && !empty;
    // Flush wins over any push landing in the same cycle.
    assign push_ok   = smp_vld_q & ~flush_w & (~full | pop);
    assign drop      = smp_vld_q & ~flush_w & full & ~pop;

    assign period_m1 = period - 16'd1;
    assign running   = en & periodic & (period != 16'd0);
    assign tick      = running && (timer == period_m1);
    assign trig_edge = trig_i & ~trig_q;
    assign sample_ev = en & (trig_edge | tick);

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    assign unused_bits = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:16]};

    // Wishbone ack and registered read data (zero whenever no ack is issued)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= rd_acc ? rd_data : 32'd0;
        end
    end

    // CTRL and PERIOD registers with byte-select write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            period   <= '0;
        end else if (wr_acc) begin
            if (ofs == OFS_CTRL && wbs_sel_i[0]) begin
                en       <= wbs_dat_i[0];
                periodic <= wbs_dat_i[1];
            end
            if (ofs == OFS_PERIOD) begin
                if (wbs_sel_i[0]) period[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) period[15:8] <= wbs_dat_i[15:8];
            end
        end
    end

    // Sticky overflow; a new drop takes priority over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Period timer: counts 0..PERIOD-1 while running, otherwise parked at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!running || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    // Trigger edge detect and one-stage capture of the sampled count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q    <= 1'b0;
            smp_vld_q <= 1'b0;
            smp_dat_q <= '0;
        end else begin
            trig_q    <= trig_i;
            smp_vld_q <= sample_ev & ~flush_w;
            if (sample_ev) smp_dat_q <= count_i;
        end
    end

    // FIFO pointers; flush clears both on the cycle after the CTRL write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_w) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= smp_dat_q;
    end

`ifdef COUNT_SAMPLE_IRQ_EN
    logic [6:0] thresh;
    logic       irq_q;

    // THRESH register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh <= '0;
        end else if (wr_acc && ofs == OFS_THRESH && wbs_sel_i[0]) begin
            thresh <= wbs_dat_i[6:0];
        end
    end

    // Level interrupt: fill level reached a non-zero threshold, or overflow pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ((thresh != 7'd0) && (level7 >= thresh)) || ovf;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Register read mux; undefined offsets and an empty DATA read return 0
    always_comb begin
        rd_data = '0;
        case (ofs)
            OFS_CTRL: begin
                rd_data[0] = en;
                rd_data[1] = periodic;
            end
            OFS_PERIOD: rd_data[15:0] = period;
            OFS_STATUS: begin
                rd_data[6:0] = level7;
                rd_data[8]   = empty;
                rd_data[9]   = full;
                rd_data[10]  = ovf;
            end
            OFS_DATA: begin
                if (!empty) rd_data[BITS-1:0] = mem[rd_ptr[AW-1:0]];
            end
`ifdef COUNT_SAMPLE_IRQ_EN
            OFS_THRESH: rd_data[6:0] = thresh;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_count_sample_fifo.sv
// Testbench for count_sample_fifo: directed steps with randomized sample values,
// checked against a queue-based model of the sampling FIFO.
module tb_count_sample_fifo;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_PERIOD = BASE + 32'h04;
    localparam logic [31:0] A_STATUS = BASE + 32'h08;
    localparam logic [31:0] A_DATA   = BASE + 32'h0C;
    localparam logic [31:0] A_THRESH = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] count_i;
    logic        trig_i = 1'b0;
    logic        irq_o;

    logic [31:0] cyc_cnt = '0;
    logic [31:0] manual_cnt = '0;
    bit          use_ramp = 1'b0;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] mq[$];
    bit          m_ovf = 1'b0;

    count_sample_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .count_i   (count_i),
        .trig_i    (trig_i),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

    assign count_i = use_ramp ? cyc_cnt : manual_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void m_sample(input logic [31:0] v);
        if (mq.size() < 8) mq.push_back(v);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'd0;
        return mq.pop_front();
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(mq.size());
        if (mq.size() == 0) s = s | 32'h100;
        if (mq.size() == 8) s = s | 32'h200;
        if (m_ovf) s = s | 32'h400;
        return s;
    endfunction

    // One Wishbone access; optionally raises trig_i in the request cycle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input bit trg, input logic [31:0] tval,
                        output logic [31:0] rd, output logic [31:0] req_cnt);
        bit got;
        got = 1'b0;
        rd = '0;
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = 4'hF;
        if (trg) begin
            manual_cnt = tval;
            trig_i = 1'b1;
        end
        req_cnt = cyc_cnt;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            trig_i = 1'b0;
            if (wbs_ack_o) begin
                got = 1'b1;
                rd = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd, rc;
        xfer(1'b1, adr, dat, 1'b0, 32'd0, rd, rc);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
        logic [31:0] rc;
        xfer(1'b0, adr, 32'd0, 1'b0, 32'd0, rd, rc);
    endtask

    // Trigger pulse with a given count value; returns once the entry (and irq) has settled.
    task automatic pulse(input logic [31:0] v);
        @(negedge clk);
        manual_cnt = v;
        trig_i = 1'b1;
        @(negedge clk);
        trig_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rc, c0, c1, v, per, nexp;
        int acks;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        rst_n = 1'b1;
        wb_rd(A_STATUS, rd); chk("rst_status", rd, 32'h100);
        wb_rd(A_CTRL, rd);   chk("rst_ctrl", rd, 32'd0);

        // single trigger, then a few random ones
        wb_wr(A_CTRL, 32'd1);
        pulse(32'h1234); m_sample(32'h1234);
        wb_rd(A_STATUS, rd); chk("t1_status", rd, 32'h001);
        wb_rd(A_DATA, rd);   chk("t1_data", rd, m_pop());
        wb_rd(A_STATUS, rd); chk("t1_empty", rd, 32'h100);
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            pulse(v); m_sample(v);
        end
        wb_rd(A_STATUS, rd); chk("rnd_status", rd, m_status());
        for (int i = 0; i < 3; i++) begin
            wb_rd(A_DATA, rd); chk("rnd_data", rd, m_pop());
        end

        // periodic sampling of a ramp: samples at C0+P*k while enabled
        wb_wr(A_CTRL, 32'd0);
        use_ramp = 1'b1;
        per = 32'($urandom_range(2, 5));
        wb_wr(A_PERIOD, per);
        xfer(1'b1, A_CTRL, 32'd3, 1'b0, 32'd0, rd, c0);
        repeat (3 * per) @(negedge clk);
        xfer(1'b1, A_CTRL, 32'd0, 1'b0, 32'd0, rd, c1);
        repeat (3) @(negedge clk);
        use_ramp = 1'b0;
        nexp = (c1 - c0) / per;
        for (logic [31:0] k = 1; k <= nexp; k++) m_sample(c0 + per * k);
        wb_rd(A_STATUS, rd); chk("per_status", rd, m_status());
        for (int i = 0; i < int'(nexp); i++) begin
            wb_rd(A_DATA, rd); chk("per_data", rd, m_pop());
        end
        wb_rd(A_PERIOD, rd); chk("per_reg", rd, per);

        // overflow: ten samples into eight entries
        wb_wr(A_CTRL, 32'd1);
        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            pulse(v); m_sample(v);
        end
        wb_rd(A_STATUS, rd); chk("ovf_status", rd, m_status());
        chk("ovf_status_const", rd, 32'h608);
        wb_wr(A_STATUS, 32'h400); m_ovf = 1'b0;
        wb_rd(A_STATUS, rd); chk("ovf_clear", rd, 32'h208);

        // full FIFO: DATA read coincident with a trigger edge
        v = $urandom;
        xfer(1'b0, A_DATA, 32'd0, 1'b1, v, rd, rc);
        chk("full_pop_push_data", rd, m_pop());
        m_sample(v);
        repeat (3) @(negedge clk);
        wb_rd(A_STATUS, rd); chk("full_pop_push_status", rd, m_status());
        for (int i = 0; i < 8; i++) begin
            wb_rd(A_DATA, rd); chk("drain_data", rd, m_pop());
        end
        wb_rd(A_STATUS, rd); chk("drain_status", rd, 32'h100);

        // flush coincident with a trigger
        pulse(32'hA5A5_0001); m_sample(32'hA5A5_0001);
        pulse(32'hA5A5_0002); m_sample(32'hA5A5_0002);
        xfer(1'b1, A_CTRL, 32'd5, 1'b1, 32'hDEAD_BEEF, rd, rc);
        mq.delete();
        repeat (3) @(negedge clk);
        wb_rd(A_STATUS, rd); chk("flush_status", rd, 32'h100);
        wb_rd(A_CTRL, rd);   chk("flush_ctrl", rd, 32'd1);
        wb_rd(A_DATA, rd);   chk("flush_data", rd, 32'd0);
        wb_wr(BASE + 32'h20, 32'hFFFF_FFFF);
        wb_rd(BASE + 32'h20, rd); chk("undef_ofs", rd, 32'd0);

        // empty FIFO: DATA read with a coincident push returns 0, push lands
        v = $urandom;
        xfer(1'b0, A_DATA, 32'd0, 1'b1, v, rd, rc);
        chk("empty_pop_push_data", rd, 32'd0);
        m_sample(v);
        repeat (3) @(negedge clk);
        wb_rd(A_DATA, rd); chk("empty_pop_push_entry", rd, m_pop());

        // held strobe is acked every other cycle; idle data is 0
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_STATUS;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("held_acks", 32'(acks), 32'd2);
        @(negedge clk);
        chk("idle_dat", wbs_dat_o, 32'd0);

        // address miss never acks
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = BASE + 32'h100;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        chk("miss_acks", 32'(acks), 32'd0);

        // threshold interrupt
        wb_wr(A_THRESH, 32'd3);
        pulse(32'h11); m_sample(32'h11);
        pulse(32'h22); m_sample(32'h22);
        chk("irq_below", 32'(irq_o), 32'd0);
        pulse(32'h33); m_sample(32'h33);
`ifdef COUNT_SAMPLE_IRQ_EN
        chk("irq_at_thresh", 32'(irq_o), 32'd1);
        wb_rd(A_THRESH, rd); chk("thresh_reg", rd, 32'd3);
        wb_rd(A_DATA, rd);   chk("irq_pop_data", rd, m_pop());
        chk("irq_still_high", 32'(irq_o), 32'd1);
        @(negedge clk);
        chk("irq_cleared", 32'(irq_o), 32'd0);
`else
        chk("irq_tied_low", 32'(irq_o), 32'd0);
        wb_rd(A_THRESH, rd); chk("thresh_absent", rd, 32'd0);
        wb_rd(A_DATA, rd);   chk("irq_pop_data", rd, m_pop());
`endif

        // reset while ack is high: ack drops at once
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
        @(posedge clk); #1;
        chk("pre_rst_ack", 32'(wbs_ack_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("mid_rst_dat", wbs_dat_o, 32'd0);
        chk("mid_rst_irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete(); m_ovf = 1'b0;

        // reset asserted inside the request cycle: that request is never acked
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = A_CTRL;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("inflight_no_ack", 32'(wbs_ack_o), 32'd0);
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb_rd(A_STATUS, rd); chk("post_rst_status", rd, m_status());
        wb_rd(A_CTRL, rd);   chk("post_rst_ctrl", rd, 32'd0);
        wb_rd(A_PERIOD, rd); chk("post_rst_period", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
